// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
// game_sequencer: plays one tic-tac-toe game against the make_turn engine.
// It owns the authoritative board registers. It alternates the mover, issues one
// request per move, and screens every reply for legality. After each accepted
// move it checks for an overlap, a win, a draw or a timeout.
module game_sequencer #(
    parameter int ROWS    = 3,
    parameter int COLS    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 first_a,
    input  logic [ROWS*COLS-1:0] init_a,
    input  logic [ROWS*COLS-1:0] init_b,
    output logic                 mt_req,
    input  logic                 mt_ready,
    output logic                 mt_target_a,
    output logic [ROWS*COLS-1:0] mt_board_a,
    output logic [ROWS*COLS-1:0] mt_board_b,
    input  logic [ROWS*COLS-1:0] mt_board_a_out,
    input  logic [ROWS*COLS-1:0] mt_board_b_out,
    input  logic                 mt_valid,
    input  logic                 mt_error,
    output logic                 busy,
    output logic                 done,
    output logic                 win_a,
    output logic                 win_b,
    output logic                 draw,
    output logic                 fault,
    output logic [7:0]           turn_count
);

    localparam int N  = ROWS * COLS;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // A wait times out on the cycle its counter would step onto TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
    localparam logic [N-1:0]  ONE      = N'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Mask of every cell in column c.
    function automatic logic [N-1:0] col_mask(input int c);
        logic [N-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) m[r*COLS+c] = 1'b1;
        return m;
    endfunction

    // Mask of the main diagonal (anti=0) or the anti-diagonal (anti=1).
    function automatic logic [N-1:0] diag_mask(input int anti);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (anti != 0) m[i*COLS+(COLS-1-i)] = 1'b1;
            else           m[i*COLS+i]          = 1'b1;
        end
        return m;
    endfunction

    state_t          state_reg, state_next;
    logic [N-1:0]    board_a_reg, board_a_next;
    logic [N-1:0]    board_b_reg, board_b_next;
    logic            target_a_reg, target_a_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [7:0]      turn_reg, turn_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            win_a_reg, win_a_next;
    logic            win_b_reg, win_b_next;
    logic            draw_reg, draw_next;
    logic            fault_reg, fault_next;

    // Per-line completion flags for both players.
    logic [ROWS-1:0] row_a, row_b;
    logic [COLS-1:0] col_a, col_b;
    logic [1:0]      diag_a, diag_b;
    logic            line_a, line_b;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_a[gi] = &board_a_reg[gi*COLS +: COLS];
            assign row_b[gi] = &board_b_reg[gi*COLS +: COLS];
        end
        for (gi = 0; gi < COLS; gi++) begin : g_col
            localparam logic [N-1:0] MASK = col_mask(gi);
            assign col_a[gi] = ((board_a_reg & MASK) == MASK);
            assign col_b[gi] = ((board_b_reg & MASK) == MASK);
        end
        if (ROWS == COLS) begin : g_diag
            for (gi = 0; gi < 2; gi++) begin : g_dir
                localparam logic [N-1:0] MASK = diag_mask(gi);
                assign diag_a[gi] = ((board_a_reg & MASK) == MASK);
                assign diag_b[gi] = ((board_b_reg & MASK) == MASK);
            end
        end else begin : g_no_diag
            // Non-square boards have no diagonals.
            assign diag_a = 2'b00;
            assign diag_b = 2'b00;
        end
    endgenerate

    assign line_a = (|row_a) | (|col_a) | (|diag_a);
    assign line_b = (|row_b) | (|col_b) | (|diag_b);

    // Reply screening: mover gains exactly one previously empty cell, other board untouched.
    logic [N-1:0] mover_reg, other_reg, mover_out, other_out, added;
    logic         legal;

    // Legality of the current make_turn reply against the board registers.
    always_comb begin
        mover_reg = target_a_reg ? board_a_reg    : board_b_reg;
        other_reg = target_a_reg ? board_b_reg    : board_a_reg;
        mover_out = target_a_reg ? mt_board_a_out : mt_board_b_out;
        other_out = target_a_reg ? mt_board_b_out : mt_board_a_out;
        added     = mover_out & ~mover_reg;
        legal     = (other_out == other_reg)
                  && ((mover_out & mover_reg) == mover_reg)
                  && (added != '0)
                  && ((added & (added - ONE)) == '0)
                  && ((added & other_reg) == '0);
    end

    // Next-state and register-update logic of the game FSM.
    always_comb begin
        state_next    = state_reg;
        board_a_next  = board_a_reg;
        board_b_next  = board_b_reg;
        target_a_next = target_a_reg;
        cnt_next      = cnt_reg;
        turn_next     = turn_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        win_a_next    = win_a_reg;
        win_b_next    = win_b_reg;
        draw_next     = draw_reg;
        fault_next    = fault_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    board_a_next  = init_a;
                    board_b_next  = init_b;
                    target_a_next = first_a;
                    turn_next     = 8'd0;
                    busy_next     = 1'b1;
                    done_next     = 1'b0;
                    win_a_next    = 1'b0;
                    win_b_next    = 1'b0;
                    draw_next     = 1'b0;
                    fault_next    = 1'b0;
                    state_next    = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = S_DONE;
                done_next  = 1'b1;
                if ((board_a_reg & board_b_reg) != '0) begin
                    fault_next = 1'b1;
                end else if (line_a) begin
                    win_a_next = 1'b1;
                end else if (line_b) begin
                    win_b_next = 1'b1;
                end else if (&(board_a_reg | board_b_reg)) begin
                    draw_next = 1'b1;
                end else begin
                    done_next  = 1'b0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mt_ready && mt_error) begin
                    draw_next  = 1'b1;
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else if (mt_ready && mt_valid) begin
                    if (legal) begin
                        board_a_next  = mt_board_a_out;
                        board_b_next  = mt_board_b_out;
                        turn_next     = (turn_reg == 8'hFF) ? turn_reg : turn_reg + 8'd1;
                        target_a_next = ~target_a_reg;
                        state_next    = S_CHECK;
                    end else begin
                        fault_next = 1'b1;
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    fault_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                // busy stays high through DONE so a start here is still ignored.
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            board_a_reg  <= '0;
            board_b_reg  <= '0;
            target_a_reg <= 1'b0;
            cnt_reg      <= '0;
            turn_reg     <= 8'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            win_a_reg    <= 1'b0;
            win_b_reg    <= 1'b0;
            draw_reg     <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            board_a_reg  <= board_a_next;
            board_b_reg  <= board_b_next;
            target_a_reg <= target_a_next;
            cnt_reg      <= cnt_next;
            turn_reg     <= turn_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            win_a_reg    <= win_a_next;
            win_b_reg    <= win_b_next;
            draw_reg     <= draw_next;
            fault_reg    <= fault_next;
        end
    end

    // Request decoded from state so it drops the instant reset asserts.
    assign mt_req      = (state_reg == S_REQ);
    assign mt_target_a = target_a_reg;
    assign mt_board_a  = board_a_reg;
    assign mt_board_b  = board_b_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign win_a       = win_a_reg;
    assign win_b       = win_b_reg;
    assign draw        = draw_reg;
    assign fault       = fault_reg;
    assign turn_count  = turn_reg;

endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
// Directed bench for game_sequencer: a behavioural make_turn (lowest free cell)
// plus stub responders for timeout, illegal reply and error reply.
module tb_game_sequencer;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         first_a;
    logic [N-1:0] init_a, init_b;
    logic         mt_req;
    logic         mt_ready;
    logic         mt_target_a;
    logic [N-1:0] mt_board_a, mt_board_b;
    logic [N-1:0] mt_board_a_out, mt_board_b_out;
    logic         mt_valid, mt_error;
    logic         busy, done, win_a, win_b, draw, fault;
    logic [7:0]   turn_count;

    int checks = 0;
    int errors = 0;

    game_sequencer #(.ROWS(3), .COLS(3), .TIMEOUT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .first_a        (first_a),
        .init_a         (init_a),
        .init_b         (init_b),
        .mt_req         (mt_req),
        .mt_ready       (mt_ready),
        .mt_target_a    (mt_target_a),
        .mt_board_a     (mt_board_a),
        .mt_board_b     (mt_board_b),
        .mt_board_a_out (mt_board_a_out),
        .mt_board_b_out (mt_board_b_out),
        .mt_valid       (mt_valid),
        .mt_error       (mt_error),
        .busy           (busy),
        .done           (done),
        .win_a          (win_a),
        .win_b          (win_b),
        .draw           (draw),
        .fault          (fault),
        .turn_count     (turn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Responder modes: 0 lowest free cell, 1 never ready, 2 mover unchanged, 3 error.
    task automatic respond(input int mode);
        logic [N-1:0] occ;
        int idx;
        mt_ready = 1'b0; mt_valid = 1'b0; mt_error = 1'b0;
        mt_board_a_out = mt_board_a;
        mt_board_b_out = mt_board_b;
        case (mode)
            0: begin
                occ = mt_board_a | mt_board_b;
                idx = -1;
                for (int i = N - 1; i >= 0; i--) if (!occ[i]) idx = i;
                mt_ready = 1'b1;
                if (idx < 0) mt_error = 1'b1;
                else begin
                    mt_valid = 1'b1;
                    if (mt_target_a) mt_board_a_out = mt_board_a | (N'(1) << idx);
                    else             mt_board_b_out = mt_board_b | (N'(1) << idx);
                end
            end
            2: begin mt_ready = 1'b1; mt_valid = 1'b1; end
            3: begin mt_ready = 1'b1; mt_error = 1'b1; end
            default: ;
        endcase
    endtask

    // Start a game and serve requests until done; optionally poke start mid-game.
    task automatic run_game(input string name, input int mode, input logic fa,
                            input logic [N-1:0] ia, input logic [N-1:0] ib,
                            input bit poke, output int reqs, output int cycles);
        mt_ready = 1'b0; mt_valid = 1'b0; mt_error = 1'b0;
        first_a = fa; init_a = ia; init_b = ib; start = 1'b1;
        step();
        start = 1'b0;
        reqs = 0;
        cycles = 0;
        while (!done && cycles < 200) begin
            if (mt_req) begin
                reqs++;
                respond(mode);
            end
            if (poke && cycles == 5) begin
                start = 1'b1; init_a = 9'h1FF; init_b = 9'h1FF; first_a = ~fa;
            end else begin
                start = 1'b0;
            end
            step();
            cycles++;
        end
        start = 1'b0;
        if (cycles >= 200) check({name, "_done_reached"}, done, 1);
        $display("game %s: reqs=%0d cycles=%0d turns=%0d a=%b b=%b win_a=%b win_b=%b draw=%b fault=%b",
                 name, reqs, cycles, turn_count, mt_board_a, mt_board_b, win_a, win_b, draw, fault);
    endtask

    initial begin
        int reqs, cycles, r;
        reset = 1'b0; start = 1'b0; first_a = 1'b0;
        init_a = '0; init_b = '0;
        mt_ready = 1'b0; mt_valid = 1'b0; mt_error = 1'b0;
        mt_board_a_out = '0; mt_board_b_out = '0;
        step(); step();

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", mt_req, 0);
        check("rst_board_a", mt_board_a, 0);
        check("rst_target", mt_target_a, 0);
        check("rst_turns", turn_count, 0);
        reset = 1'b1;
        step();

        // Full game, a first, with an ignored start pulse mid-game.
        run_game("a_first", 0, 1'b1, 9'b0, 9'b0, 1'b1, reqs, cycles);
        check("g1_reqs", reqs, 7);
        check("g1_board_a", mt_board_a, 9'b001010101);
        check("g1_board_b", mt_board_b, 9'b000101010);
        check("g1_win_a", win_a, 1);
        check("g1_win_b", win_b, 0);
        check("g1_fault", fault, 0);
        check("g1_turns", turn_count, 7);
        step();
        check("g1_busy_low", busy, 0);
        step(); step();
        check("g1_done_held", done, 1);
        check("g1_win_held", win_a, 1);

        // Full game, b first.
        run_game("b_first", 0, 1'b0, 9'b0, 9'b0, 1'b0, reqs, cycles);
        check("g2_reqs", reqs, 7);
        check("g2_board_b", mt_board_b, 9'b001010101);
        check("g2_board_a", mt_board_a, 9'b000101010);
        check("g2_win_b", win_b, 1);
        check("g2_win_a", win_a, 0);
        check("g2_turns", turn_count, 7);
        step(); step();

        // Full board without a line: draw two cycles after start.
        run_game("draw", 0, 1'b1, 9'b101100011, 9'b010011100, 1'b0, reqs, cycles);
        check("g3_reqs", reqs, 0);
        check("g3_latency", cycles, 1);
        check("g3_draw", draw, 1);
        check("g3_done", done, 1);
        check("g3_turns", turn_count, 0);
        check("g3_win_a", win_a, 0);
        step(); step();

        // Overlapping initial boards.
        run_game("overlap", 0, 1'b1, 9'b000000001, 9'b000000001, 1'b0, reqs, cycles);
        check("g4_reqs", reqs, 0);
        check("g4_fault", fault, 1);
        check("g4_draw", draw, 0);
        step(); step();

        // Timeout: fault exactly 16 cycles after the request pulse.
        mt_ready = 1'b0; mt_valid = 1'b0; mt_error = 1'b0;
        first_a = 1'b1; init_a = '0; init_b = '0; start = 1'b1;
        step();
        start = 1'b0;
        r = 0;
        while (!mt_req && r < 20) begin step(); r++; end
        check("to_req_seen", mt_req, 1);
        for (int k = 1; k <= 15; k++) step();
        check("to_fault_early", fault, 0);
        step();
        check("to_fault", fault, 1);
        check("to_busy_still", busy, 1);
        step();
        check("to_busy_low", busy, 0);
        check("to_done", done, 1);
        $display("game timeout: fault=%b busy=%b done=%b", fault, busy, done);
        step();

        // Reply with mover board unchanged.
        run_game("illegal", 2, 1'b1, 9'b0, 9'b0, 1'b0, reqs, cycles);
        check("g6_fault", fault, 1);
        check("g6_board_a", mt_board_a, 0);
        check("g6_turns", turn_count, 0);
        step(); step();

        // make_turn reports no move.
        run_game("mt_error", 3, 1'b1, 9'b0, 9'b0, 1'b0, reqs, cycles);
        check("g7_draw", draw, 1);
        check("g7_fault", fault, 0);
        step(); step();

        // Reset asserted mid-WAIT aborts immediately.
        mt_ready = 1'b0; mt_valid = 1'b0; mt_error = 1'b0;
        first_a = 1'b1; init_a = 9'b000000001; init_b = '0; start = 1'b1;
        step();
        start = 1'b0;
        r = 0;
        while (!mt_req && r < 20) begin step(); r++; end
        step(); step();
        check("ab_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("ab_busy", busy, 0);
        check("ab_req", mt_req, 0);
        check("ab_board_a", mt_board_a, 0);
        check("ab_target", mt_target_a, 0);
        check("ab_done", done, 0);
        $display("abort: busy=%b req=%b board_a=%b", busy, mt_req, mt_board_a);
        step();
        reset = 1'b1;
        step();

        // Normal game after the abort.
        run_game("after_reset", 0, 1'b0, 9'b0, 9'b0, 1'b0, reqs, cycles);
        check("g8_win_b", win_b, 1);
        check("g8_turns", turn_count, 7);
        check("g8_board_b", mt_board_b, 9'b001010101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Drives the make_turn engine as the requesting side. It plays a complete tic-tac-toe game by alternating target_a, issuing one req per move and capturing each returned board pair. After every move it checks the result for legality, a win, a draw or a timeout. It sits between the top-level game control and make_turn, and owns the authoritative board registers.

Parameters:
ROWS, 3, board rows.
COLS, 3, board columns. Cell (r,c) maps to bit r*COLS+c.
TIMEOUT, 1024, maximum cycles spent in WAIT before a fault is raised.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted at 0).
start  in  1  one-cycle pulse that starts a game. Ignored while busy=1.
first_a  in  1  1 means player a moves first. Sampled on start.
init_a  in  ROWS*COLS  initial board for player a. Sampled on start.
init_b  in  ROWS*COLS  initial board for player b. Sampled on start.
mt_req  out  1  request pulse to make_turn.
mt_ready  in  1  make_turn result available.
mt_target_a  out  1  1 means make_turn updates board_a.
mt_board_a  out  ROWS*COLS  board a sent to make_turn (board_a register).
mt_board_b  out  ROWS*COLS  board b sent to make_turn (board_b register).
mt_board_a_out  in  ROWS*COLS  board a returned by make_turn.
mt_board_b_out  in  ROWS*COLS  board b returned by make_turn.
mt_valid  in  1  make_turn found a move.
mt_error  in  1  make_turn found no move.
busy  out  1  game in progress.
done  out  1  game finished. Held until the next accepted start.
win_a  out  1  player a completed a line.
win_b  out  1  player b completed a line.
draw  out  1  board full with no line completed.
fault  out  1  overlap, illegal response or timeout.
turn_count  out  8  moves accepted in the current game.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0, the board registers are 0 and mt_target_a=0.
- IDLE:
  - On start=1: load board_a/board_b from init_a/init_b, set mt_target_a=first_a, clear done/win/draw/fault/turn_count, set busy=1, go to CHECK.
- CHECK (1 cycle), evaluated in priority order:
  1. board_a & board_b nonzero -> fault.
  2. Player a has a full row, column or diagonal -> win_a.
  3. Player b has a full row, column or diagonal -> win_b.
  4. board_a | board_b all ones -> draw.
  5. Otherwise go to REQ.
  - Diagonals are checked only when ROWS==COLS.
  - Outcomes 1-4 go to DONE.
- REQ: mt_req=1 for exactly one cycle, then go to WAIT and clear the timeout counter. mt_board_a/b and mt_target_a stay stable from REQ until the response is accepted.
- WAIT: the response is accepted on the first cycle where mt_ready=1 and (mt_valid|mt_error)=1. The earliest possible acceptance is the cycle after mt_req.
  - mt_error=1: go to DONE with draw=1. The boards are not updated.
  - mt_valid=1: the response is legal only if all of these hold:
    - the non-mover's returned board equals its register;
    - the mover's returned board is a superset of its register with exactly one added bit;
    - the added bit was previously empty in both boards.
  - Legal response: latch the returned boards, turn_count+1, invert mt_target_a, go to CHECK.
  - Illegal response: fault, go to DONE.
  - mt_valid and mt_error both 1: mt_error takes priority.
  - Timeout: the counter increments each WAIT cycle. When it reaches TIMEOUT-1 without an accepted response, raise fault and go to DONE.
- DONE: busy=0, done=1, go to IDLE. Exactly one of win_a/win_b/draw/fault is 1. Results and boards are held until the next start.
- start while busy=1 is ignored, with no effect on state or outputs.
- turn_count saturates at 255. It cannot exceed ROWS*COLS in legal play.
- mt_req never asserts in IDLE, CHECK, WAIT or DONE.
- A reset assertion mid-game aborts immediately and mt_req drops asynchronously.

Test Plan:
- Real make_turn (picks lowest free cell), empty init, first_a=1, start -> 7 mt_req pulses; final board_a=9'b001010101, board_b=9'b000101010, win_a=1, turn_count=7, fault=0.
- Same as above with first_a=0 -> board_b=9'b001010101, board_a=9'b000101010, win_b=1, turn_count=7.
- init_a=9'b101100011, init_b=9'b010011100 -> no mt_req pulse, draw=1, turn_count=0, done=1 two cycles after start.
- init_a=9'b000000001, init_b=9'b000000001 -> fault=1, no mt_req pulse.
- Stub make_turn holds mt_ready=0, TIMEOUT=16 -> fault=1 exactly 16 cycles after the mt_req pulse; busy drops the cycle after.
- Stub returns mover board unchanged with mt_valid=1 -> fault=1, boards unchanged. Then reset=0 mid-WAIT on a fresh game -> all outputs 0 immediately; start afterwards runs normally.
